// File: rtl/picobello_pkg.sv
// Shared types and defaults for the per-tile power sequencer.
package picobello_pkg;

    localparam int unsigned TileRstHoldCycles   = 8;
    localparam int unsigned TileClkSettleCycles = 4;
    localparam int unsigned TileDrainTimeout    = 1024;

    typedef enum logic [2:0] {
        TILE_OFF,
        TILE_RST_CLK,
        TILE_RELEASE,
        TILE_ON,
        TILE_DRAIN,
        TILE_RST_ASSERT
    } tile_pwr_state_e;

    // Static per-state drive of the tile and chimney.
    typedef struct packed {
        logic clk_en;
        logic rst_n;
        logic isolate;
        logic ready;
        logic tile_on;
    } tile_pwr_out_t;

    localparam tile_pwr_out_t TilePwrOutOff = '{
        clk_en: 1'b0, rst_n: 1'b0, isolate: 1'b1, ready: 1'b1, tile_on: 1'b0
    };

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic tile_pwr_out_t tile_pwr_outputs(input tile_pwr_state_e s);
        tile_pwr_out_t o;
        o = TilePwrOutOff;
        case (s)
            TILE_RST_CLK: begin
                o.clk_en = 1'b1;
                o.ready  = 1'b0;
            end
            TILE_RELEASE, TILE_DRAIN: begin
                o.clk_en = 1'b1;
                o.rst_n  = 1'b1;
                o.ready  = 1'b0;
            end
            TILE_ON: begin
                o.clk_en  = 1'b1;
                o.rst_n   = 1'b1;
                o.isolate = 1'b0;
                o.tile_on = 1'b1;
            end
            TILE_RST_ASSERT: begin
                o.clk_en = 1'b1;
                o.ready  = 1'b0;
            end
            default: o = TilePwrOutOff;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/tile_pwr_ctrl_if.sv
// Command handshake plus tile/chimney control lines of one tile power sequencer.
interface tile_pwr_ctrl_if;
    logic cmd_valid_i;
    logic cmd_ready_o;
    logic cmd_on_i;
    logic tile_idle_i;
    logic isolate_o;
    logic tile_clk_en_o;
    logic tile_rst_no;
    logic on_o;
    logic done_o;
    logic err_o;

    modport master (
        output cmd_valid_i, cmd_on_i, tile_idle_i,
        input  cmd_ready_o, isolate_o, tile_clk_en_o, tile_rst_no, on_o, done_o, err_o
    );

    modport slave (
        input  cmd_valid_i, cmd_on_i, tile_idle_i,
        output cmd_ready_o, isolate_o, tile_clk_en_o, tile_rst_no, on_o, done_o, err_o
    );
endinterface

// File: rtl/tile_pwr_ctrl.sv
// Per-tile clock-enable / reset sequencer with NoC drain and chimney isolation.
// Lives on the free-running clk_i, outside the tile's gated domain.
module tile_pwr_ctrl
    import picobello_pkg::*;
#(
    parameter int unsigned RstHoldCycles   = TileRstHoldCycles,
    parameter int unsigned ClkSettleCycles = TileClkSettleCycles,
    parameter int unsigned DrainTimeout    = TileDrainTimeout
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    tile_pwr_ctrl_if.slave bus
);

    localparam int unsigned MaxCycles = max3(RstHoldCycles, ClkSettleCycles, DrainTimeout);
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    tile_pwr_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    tile_pwr_out_t   out_q, out_d;
    logic            err_q, err_d;
    logic            done_q, done_d;
    logic            accept;

    assign accept = bus.cmd_valid_i & out_q.ready;

    // State, shared counter and all output flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= TILE_OFF;
            cnt_q   <= '0;
            out_q   <= TilePwrOutOff;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Next state; outputs are pre-decoded from the next state so they leave flops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        done_d  = 1'b0;

        if (accept) begin
            err_d = 1'b0;
        end

        unique case (state_q)
            TILE_OFF: begin
                if (accept && bus.cmd_on_i) begin
                    state_d = TILE_RST_CLK;
                    cnt_d   = CntW'(RstHoldCycles - 1);
                end
            end
            TILE_RST_CLK: begin
                if (cnt_q == '0) begin
                    state_d = TILE_RELEASE;
                    cnt_d   = CntW'(ClkSettleCycles - 1);
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            TILE_RELEASE: begin
                if (cnt_q == '0) begin
                    state_d = TILE_ON;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            TILE_ON: begin
                if (accept && !bus.cmd_on_i) begin
                    state_d = TILE_DRAIN;
                    cnt_d   = '0;
                end
            end
            TILE_DRAIN: begin
                // Idle beats a coincident timeout, so it is checked first.
                if (bus.tile_idle_i) begin
                    state_d = TILE_RST_ASSERT;
                    cnt_d   = CntW'(RstHoldCycles - 1);
                end else if ((DrainTimeout != 0) && (cnt_q == CntW'(DrainTimeout - 1))) begin
                    state_d = TILE_RST_ASSERT;
                    cnt_d   = CntW'(RstHoldCycles - 1);
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            TILE_RST_ASSERT: begin
                if (cnt_q == '0) begin
                    state_d = TILE_OFF;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d = TILE_OFF;
                cnt_d   = '0;
            end
        endcase

        out_d = tile_pwr_outputs(state_d);
    end

    assign bus.cmd_ready_o   = out_q.ready;
    assign bus.isolate_o     = out_q.isolate;
    assign bus.tile_clk_en_o = out_q.clk_en;
    assign bus.tile_rst_no   = out_q.rst_n;
    assign bus.on_o          = out_q.tile_on;
    assign bus.done_o        = done_q;
    assign bus.err_o         = err_q;

endmodule

// File: tb/tb_tile_pwr_ctrl.sv
// Bench for tile_pwr_ctrl: directed sequences then random commands/idle, checked
// every cycle against a timeline model built from event times.
module tb_tile_pwr_ctrl;

    localparam int unsigned R  = 8;
    localparam int unsigned C  = 4;
    localparam int unsigned DT = 16;

    logic clk;
    logic rst_n;

    tile_pwr_ctrl_if bus_if();

    tile_pwr_ctrl #(
        .RstHoldCycles  (R),
        .ClkSettleCycles(C),
        .DrainTimeout   (DT)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: sequence kind (0 none, 1 power-up, 2 power-down), accept edge t0,
    // drain-end cycle kd (0 = still draining), logical tile power and error flag.
    int unsigned ecnt, t0, kd;
    int          seq;
    bit          m_on, m_err, m_acc;
    bit          e_clk, e_rst, e_iso, e_rdy, e_on, e_done;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, ecnt);
        end
    endtask

    task automatic set_exp(input bit ck, input bit rs, input bit is, input bit rd, input bit on);
        e_clk = ck; e_rst = rs; e_iso = is; e_rdy = rd; e_on = on;
    endtask

    task automatic set_steady();
        if (m_on) set_exp(1, 1, 0, 1, 1);
        else      set_exp(0, 0, 1, 1, 0);
    endtask

    task automatic model_reset();
        seq = 0; m_on = 0; m_err = 0; m_acc = 0; e_done = 0; kd = 0; t0 = ecnt;
        set_steady();
    endtask

    // Advance the model by one clock edge given the inputs sampled at that edge.
    task automatic model_edge(input bit v, input bit on, input bit idle);
        int unsigned c, n;
        ecnt++;
        c = ecnt - t0;
        if (seq == 2 && kd == 0) begin
            if (idle) kd = c;
            else if (DT != 0 && c == DT) begin
                kd    = c;
                m_err = 1;
            end
        end
        m_acc = v && e_rdy;
        if (m_acc) begin
            m_err = 0;
            if (on && !m_on) begin
                seq = 1; t0 = ecnt;
            end else if (!on && m_on) begin
                seq = 2; t0 = ecnt; kd = 0;
            end
        end
        n      = ecnt + 1 - t0;
        e_done = 0;
        if (seq == 1) begin
            if (n <= R)          set_exp(1, 0, 1, 0, 0);
            else if (n <= R + C) set_exp(1, 1, 1, 0, 0);
            else begin
                m_on = 1; seq = 0; e_done = 1;
            end
        end else if (seq == 2) begin
            if (kd == 0)          set_exp(1, 1, 1, 0, 0);
            else if (n - kd <= R) set_exp(1, 0, 1, 0, 0);
            else begin
                m_on = 0; seq = 0; e_done = 1;
            end
        end
        if (seq == 0) set_steady();
    endtask

    task automatic check_outputs();
        check_eq("clk_en",  32'(bus_if.tile_clk_en_o), 32'(e_clk));
        check_eq("rst_n",   32'(bus_if.tile_rst_no),   32'(e_rst));
        check_eq("isolate", 32'(bus_if.isolate_o),     32'(e_iso));
        check_eq("ready",   32'(bus_if.cmd_ready_o),   32'(e_rdy));
        check_eq("on",      32'(bus_if.on_o),          32'(e_on));
        check_eq("done",    32'(bus_if.done_o),        32'(e_done));
        check_eq("err",     32'(bus_if.err_o),         32'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(bus_if.cmd_valid_i, bus_if.cmd_on_i, bus_if.tile_idle_i);
        #1;
        check_outputs();
    endtask

    task automatic cmd(input bit on);
        bus_if.cmd_valid_i = 1'b1;
        bus_if.cmd_on_i    = on;
        tick();
        bus_if.cmd_valid_i = 1'b0;
    endtask

    initial begin
        rst_n              = 1'b0;
        bus_if.cmd_valid_i = 1'b0;
        bus_if.cmd_on_i    = 1'b0;
        bus_if.tile_idle_i = 1'b0;
        ecnt               = 0;
        model_reset();

        #12;
        check_outputs();
        #1 rst_n = 1'b1;
        repeat (2) tick();

        // Redundant off while OFF, then full power-up with defaults.
        cmd(1'b0);
        repeat (2) tick();
        cmd(1'b1);
        repeat (R + C + 2) tick();

        // Redundant on while ON, then power-down with idle held high.
        cmd(1'b1);
        tick();
        bus_if.tile_idle_i = 1'b1;
        cmd(1'b0);
        repeat (R + 4) tick();
        bus_if.tile_idle_i = 1'b0;

        // Off held valid through power-up, then drain times out without idle.
        bus_if.cmd_valid_i = 1'b1;
        bus_if.cmd_on_i    = 1'b1;
        tick();
        bus_if.cmd_on_i = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (m_acc) break;
        end
        bus_if.cmd_valid_i = 1'b0;
        repeat (DT + R + 4) tick();

        // Next on clears the sticky error.
        cmd(1'b1);
        repeat (R + C + 2) tick();

        // Idle first seen in the timeout cycle: no error.
        cmd(1'b0);
        repeat (DT - 1) tick();
        bus_if.tile_idle_i = 1'b1;
        tick();
        bus_if.tile_idle_i = 1'b0;
        repeat (R + 3) tick();

        // Asynchronous reset while in RELEASE, then a clean power-up.
        cmd(1'b1);
        repeat (R + 1) tick();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        tick();
        #2 rst_n = 1'b1;
        tick();
        cmd(1'b1);
        repeat (R + C + 2) tick();

        // Random commands and idle behaviour.
        for (int i = 0; i < 1500; i++) begin
            if (!(bus_if.cmd_valid_i && !m_acc)) begin
                bus_if.cmd_valid_i = ($urandom_range(0, 3) == 0);
                bus_if.cmd_on_i    = 1'($urandom_range(0, 1));
            end
            bus_if.tile_idle_i = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
